// File: rtl/fetch_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : fetch_pkg
//  Description : Shared types and constants for the instruction-fetch
//                sequencer (state encoding, PC step, instruction width,
//                canonical NOP word).
//  Macro       : PC_CTRL_MISALIGN_TRAP_EN adds the FAULT state.
//  Revision    : 1.0 - initial release
// ============================================================================
package fetch_pkg;

    localparam int INSTR_W = 32;
    localparam int PC_INC  = 4;

    // addi x0, x0, 0
    localparam logic [INSTR_W-1:0] NOP = 32'h0000_0013;

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_REQ   = 3'd1,
        S_WAIT  = 3'd2,
        S_HOLD  = 3'd3
`ifdef PC_CTRL_MISALIGN_TRAP_EN
        ,
        S_FAULT = 3'd4
`endif
    } fetch_state_t;

endpackage
`default_nettype wire

// File: rtl/fetch_buf.sv
`default_nettype none
// ============================================================================
//  Module      : fetch_buf
//  Description : One-entry holding register presenting a fetched instruction
//                and its PC to decode. Flush beats load beats consume.
//  Revision    : 1.0 - initial release
// ============================================================================
module fetch_buf
    import fetch_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               load,
    input  logic               consume,
    input  logic               flush,
    input  logic [INSTR_W-1:0] load_instr,
    input  logic [WIDTH-1:0]   load_pc,
    output logic               valid,
    output logic [INSTR_W-1:0] instr,
    output logic [WIDTH-1:0]   pc
);

    // Entry state: a redirect empties the entry even if a load races it.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            valid <= 1'b0;
            instr <= '0;
            pc    <= '0;
        end else if (flush) begin
            valid <= 1'b0;
        end else if (load) begin
            valid <= 1'b1;
            instr <= load_instr;
            pc    <= load_pc;
        end else if (consume) begin
            valid <= 1'b0;
        end
    end

endmodule
`default_nettype wire

// File: rtl/fetch_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : fetch_ctrl
//  Description : RV32I instruction-fetch sequencer. Owns the PC, issues one
//                outstanding request at a time over a valid/ready handshake,
//                holds the returned instruction for decode, applies execute
//                redirects and discards responses made stale by a redirect.
//  Macro       : PC_CTRL_MISALIGN_TRAP_EN - a redirect to a non-word-aligned
//                target raises a sticky misalign_fault and parks the
//                sequencer in FAULT until reset. When undefined the two
//                target LSBs are ignored.
//  Revision    : 1.0 - initial release
// ============================================================================
module fetch_ctrl
    import fetch_pkg::*;
#(
    parameter int               WIDTH        = 32,
    parameter logic [WIDTH-1:0] RESET_VECTOR = 32'h0000_0000
) (
    input  logic               clk,
    input  logic               rst,
    output logic               imem_req_valid,
    input  logic               imem_req_ready,
    output logic [WIDTH-1:0]   imem_addr,
    input  logic               imem_rsp_valid,
    input  logic [INSTR_W-1:0] imem_rsp_data,
    output logic               if_valid,
    output logic [INSTR_W-1:0] if_instr,
    output logic [WIDTH-1:0]   if_pc,
    input  logic               if_ready,
    input  logic               redirect_valid,
    input  logic [WIDTH-1:0]   redirect_target,
    input  logic               halt,
    output logic               misalign_fault
);

    fetch_state_t     state;
    logic [WIDTH-1:0] pc;
    logic [WIDTH-1:0] req_pc;
    logic [WIDTH-1:0] pc_inc;
    logic [WIDTH-1:0] tgt;
    logic             drop;
    logic             handshake;
    logic             redir;
    logic             buf_load;
    logic             buf_consume;
    logic             buf_flush;

    // The address register is the PC itself; memory samples it only when the
    // handshake completes, so its value outside REQ is irrelevant.
    assign imem_addr = pc;
    assign handshake = imem_req_valid & imem_req_ready;
    assign pc_inc    = pc + WIDTH'(PC_INC);

`ifdef PC_CTRL_MISALIGN_TRAP_EN
    logic fault_hit;
    assign tgt       = redirect_target;
    assign redir     = redirect_valid && (state != S_FAULT);
    assign fault_hit = redir && (redirect_target[1:0] != 2'b00);
`else
    logic unused_tgt_lsb;
    assign unused_tgt_lsb = |redirect_target[1:0];
    assign tgt            = {redirect_target[WIDTH-1:2], 2'b00};
    assign redir          = redirect_valid;
    assign misalign_fault = 1'b0;
`endif

    // A response is only kept when nothing has made it stale.
    assign buf_load    = (state == S_WAIT) && imem_rsp_valid && !drop && !redirect_valid;
    assign buf_consume = (state == S_HOLD) && if_ready;
    assign buf_flush   = redirect_valid;

    fetch_buf #(
        .WIDTH      (WIDTH)
    ) u_buf (
        .clk        (clk),
        .rst        (rst),
        .load       (buf_load),
        .consume    (buf_consume),
        .flush      (buf_flush),
        .load_instr (imem_rsp_data),
        .load_pc    (req_pc),
        .valid      (if_valid),
        .instr      (if_instr),
        .pc         (if_pc)
    );

    // Fetch sequencer: PC, request valid, drop marker and fault flag.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state          <= S_IDLE;
            pc             <= RESET_VECTOR;
            req_pc         <= RESET_VECTOR;
            drop           <= 1'b0;
            imem_req_valid <= 1'b0;
`ifdef PC_CTRL_MISALIGN_TRAP_EN
            misalign_fault <= 1'b0;
`endif
        end else begin
`ifdef PC_CTRL_MISALIGN_TRAP_EN
            if (fault_hit) begin
                // Park: no more requests, any in-flight response is ignored.
                state          <= S_FAULT;
                imem_req_valid <= 1'b0;
                drop           <= 1'b0;
                misalign_fault <= 1'b1;
            end else begin
`endif
            case (state)
                S_IDLE: begin
                    if (redir) begin
                        pc <= tgt;
                    end
                    if (!halt) begin
                        state          <= S_REQ;
                        imem_req_valid <= 1'b1;
                    end
                end

                S_REQ: begin
                    if (handshake) begin
                        // Request counts as issued; a concurrent redirect
                        // makes its response stale.
                        req_pc         <= pc;
                        pc             <= redir ? tgt : pc_inc;
                        drop           <= redir;
                        imem_req_valid <= 1'b0;
                        state          <= S_WAIT;
                    end else if (redir) begin
                        pc <= tgt;
                    end
                end

                S_WAIT: begin
                    if (redir) begin
                        pc <= tgt;
                    end
                    if (imem_rsp_valid) begin
                        drop <= 1'b0;
                        if (drop || redir) begin
                            state          <= halt ? S_IDLE : S_REQ;
                            imem_req_valid <= !halt;
                        end else begin
                            state <= S_HOLD;
                        end
                    end else if (redir) begin
                        drop <= 1'b1;
                    end
                end

                S_HOLD: begin
                    // A redirect discards the held word without waiting
                    // for decode.
                    if (redir || if_ready) begin
                        if (redir) begin
                            pc <= tgt;
                        end
                        state          <= halt ? S_IDLE : S_REQ;
                        imem_req_valid <= !halt;
                    end
                end

`ifdef PC_CTRL_MISALIGN_TRAP_EN
                S_FAULT: begin
                    imem_req_valid <= 1'b0;
                end
`endif

                default: begin
                    state          <= S_IDLE;
                    imem_req_valid <= 1'b0;
                end
            endcase
`ifdef PC_CTRL_MISALIGN_TRAP_EN
            end
`endif
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_fetch_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : tb_fetch_ctrl
//  Description : Self-checking bench for fetch_ctrl. A behavioural instruction
//                memory answers each accepted request after rsp_lat cycles;
//                issued addresses and delivered instructions are compared
//                against expectations queued by each scenario.
//  Macro       : PC_CTRL_MISALIGN_TRAP_EN selects the misalign expectations.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_fetch_ctrl;
    import fetch_pkg::*;

    localparam int WIDTH = 32;

    logic               clk = 1'b0;
    logic               rst;
    logic               imem_req_valid;
    logic               imem_req_ready;
    logic [WIDTH-1:0]   imem_addr;
    logic               imem_rsp_valid = 1'b0;
    logic [INSTR_W-1:0] imem_rsp_data  = NOP;
    logic               if_valid;
    logic [INSTR_W-1:0] if_instr;
    logic [WIDTH-1:0]   if_pc;
    logic               if_ready;
    logic               redirect_valid;
    logic [WIDTH-1:0]   redirect_target;
    logic               halt;
    logic               misalign_fault;

    int checks = 0;
    int errors = 0;
    int rsp_lat = 1;
    int pend_cnt = 0;
    logic [31:0] pend_addr = '0;
    logic        hs_prev = 1'b0;
    logic [31:0] hs_addr = '0;

    logic [31:0] iss_q[$];
    logic [31:0] dpc_q[$];
    logic [31:0] dins_q[$];
    logic [31:0] exp_addr_q[$];
    logic [31:0] exp_pc_q[$];
    logic [31:0] e;
    logic [31:0] o;
    logic [31:0] oi;

    always #5 clk = ~clk;

    fetch_ctrl #(
        .WIDTH           (WIDTH),
        .RESET_VECTOR    (32'h0000_0000)
    ) dut (
        .clk             (clk),
        .rst             (rst),
        .imem_req_valid  (imem_req_valid),
        .imem_req_ready  (imem_req_ready),
        .imem_addr       (imem_addr),
        .imem_rsp_valid  (imem_rsp_valid),
        .imem_rsp_data   (imem_rsp_data),
        .if_valid        (if_valid),
        .if_instr        (if_instr),
        .if_pc           (if_pc),
        .if_ready        (if_ready),
        .redirect_valid  (redirect_valid),
        .redirect_target (redirect_target),
        .halt            (halt),
        .misalign_fault  (misalign_fault)
    );

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return a ^ 32'h5A5A_0013;
    endfunction

    // Memory model: responses change 1 time unit after the edge, handshakes
    // and deliveries are observed 2 time units after it (inputs settled).
    always begin
        @(posedge clk);
        #1;
        if (hs_prev) begin
            pend_cnt  = rsp_lat;
            pend_addr = hs_addr;
        end
        if (pend_cnt == 1) begin
            imem_rsp_valid = 1'b1;
            imem_rsp_data  = mem_word(pend_addr);
            pend_cnt       = 0;
        end else begin
            imem_rsp_valid = 1'b0;
            imem_rsp_data  = NOP;
            if (pend_cnt > 1) pend_cnt = pend_cnt - 1;
        end
        #1;
        hs_prev = imem_req_valid && imem_req_ready;
        hs_addr = imem_addr;
        if (hs_prev) iss_q.push_back(imem_addr);
        if (if_valid && if_ready) begin
            dpc_q.push_back(if_pc);
            dins_q.push_back(if_instr);
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        halt           = 1'b1;
        if_ready       = 1'b1;
        imem_req_ready = 1'b1;
        redirect_valid = 1'b0;
        repeat (10) step();
        rsp_lat = 1;
        iss_q.delete();
        dpc_q.delete();
        dins_q.delete();
        exp_addr_q.delete();
        exp_pc_q.delete();
    endtask

    task automatic set_pc(input logic [31:0] t);
        redirect_valid  = 1'b1;
        redirect_target = t;
        step();
        redirect_valid  = 1'b0;
    endtask

    task automatic test_reset();
        repeat (3) step();
        checks++; if (imem_req_valid !== 1'b0) begin errors++; $display("FAIL reset_req_valid got %0b exp 0", imem_req_valid); end
        checks++; if (imem_addr !== 32'h0) begin errors++; $display("FAIL reset_addr got %h exp 00000000", imem_addr); end
        checks++; if (if_valid !== 1'b0) begin errors++; $display("FAIL reset_if_valid got %0b exp 0", if_valid); end
        checks++; if (if_instr !== 32'h0) begin errors++; $display("FAIL reset_if_instr got %h exp 00000000", if_instr); end
        checks++; if (if_pc !== 32'h0) begin errors++; $display("FAIL reset_if_pc got %h exp 00000000", if_pc); end
        checks++; if (misalign_fault !== 1'b0) begin errors++; $display("FAIL reset_fault got %0b exp 0", misalign_fault); end
        rst = 1'b0;
        repeat (3) step();
        checks++; if (imem_req_valid !== 1'b0) begin errors++; $display("FAIL halted_idle_req got %0b exp 0", imem_req_valid); end
        checks++; if (iss_q.size() != 0) begin errors++; $display("FAIL halted_idle_issued got %0d exp 0", iss_q.size()); end
    endtask

    task automatic test_sequential();
        exp_addr_q = '{32'h0, 32'h4, 32'h8};
        exp_pc_q   = '{32'h0, 32'h4, 32'h8};
        halt = 1'b0;                       // IDLE sees halt=0
        step();
        checks++; if (imem_req_valid !== 1'b1 || imem_addr !== 32'h0) begin errors++; $display("FAIL seq_first_req got v=%0b a=%h exp v=1 a=00000000", imem_req_valid, imem_addr); end
        step();                            // response cycle
        checks++; if (if_valid !== 1'b0) begin errors++; $display("FAIL seq_if_early got %0b exp 0", if_valid); end
        step();
        checks++; if (if_valid !== 1'b1 || if_instr !== mem_word(32'h0)) begin errors++; $display("FAIL seq_if_latency got v=%0b i=%h exp v=1 i=%h", if_valid, if_instr, mem_word(32'h0)); end
        repeat (6) step();                 // HOLD of third word
        halt = 1'b1;
        repeat (6) step();
        checks++; if (iss_q.size() != exp_addr_q.size()) begin errors++; $display("FAIL seq_issue_count got %0d exp %0d", iss_q.size(), exp_addr_q.size()); end
        checks++; if (dpc_q.size() != exp_pc_q.size()) begin errors++; $display("FAIL seq_deliver_count got %0d exp %0d", dpc_q.size(), exp_pc_q.size()); end
        while (exp_addr_q.size() > 0) begin
            e = exp_addr_q.pop_front();
            o = (iss_q.size() > 0) ? iss_q.pop_front() : 32'hDEAD_BEEF;
            checks++; if (o !== e) begin errors++; $display("FAIL seq_addr got %h exp %h", o, e); end
        end
        while (exp_pc_q.size() > 0) begin
            e  = exp_pc_q.pop_front();
            o  = (dpc_q.size() > 0) ? dpc_q.pop_front() : 32'hDEAD_BEEF;
            oi = (dins_q.size() > 0) ? dins_q.pop_front() : 32'hDEAD_BEEF;
            checks++; if (o !== e || oi !== mem_word(e)) begin errors++; $display("FAIL seq_deliver got pc=%h i=%h exp pc=%h i=%h", o, oi, e, mem_word(e)); end
        end
    endtask

    task automatic test_redirect_wait();
        settle();
        set_pc(32'h40);
        rsp_lat    = 3;
        exp_addr_q = '{32'h40, 32'h100};
        exp_pc_q   = '{32'h100};
        halt = 1'b0;
        step();                            // REQ 0x40 accepted
        step();                            // WAIT
        redirect_valid  = 1'b1;
        redirect_target = 32'h100;
        step();
        redirect_valid  = 1'b0;
        checks++; if (if_valid !== 1'b0) begin errors++; $display("FAIL rw_if_c3 got %0b exp 0", if_valid); end
        step();                            // stale response arrives
        checks++; if (if_valid !== 1'b0) begin errors++; $display("FAIL rw_if_c4 got %0b exp 0", if_valid); end
        step();
        checks++; if (imem_req_valid !== 1'b1 || imem_addr !== 32'h100 || if_valid !== 1'b0) begin errors++; $display("FAIL rw_next_req got v=%0b a=%h if=%0b exp v=1 a=00000100 if=0", imem_req_valid, imem_addr, if_valid); end
        repeat (4) step();
        halt = 1'b1;
        repeat (6) step();
        checks++; if (iss_q.size() != exp_addr_q.size()) begin errors++; $display("FAIL rw_issue_count got %0d exp %0d", iss_q.size(), exp_addr_q.size()); end
        checks++; if (dpc_q.size() != exp_pc_q.size()) begin errors++; $display("FAIL rw_deliver_count got %0d exp %0d", dpc_q.size(), exp_pc_q.size()); end
        while (exp_addr_q.size() > 0) begin
            e = exp_addr_q.pop_front();
            o = (iss_q.size() > 0) ? iss_q.pop_front() : 32'hDEAD_BEEF;
            checks++; if (o !== e) begin errors++; $display("FAIL rw_addr got %h exp %h", o, e); end
        end
        while (exp_pc_q.size() > 0) begin
            e  = exp_pc_q.pop_front();
            o  = (dpc_q.size() > 0) ? dpc_q.pop_front() : 32'hDEAD_BEEF;
            oi = (dins_q.size() > 0) ? dins_q.pop_front() : 32'hDEAD_BEEF;
            checks++; if (o !== e || oi !== mem_word(e)) begin errors++; $display("FAIL rw_deliver got pc=%h i=%h exp pc=%h i=%h", o, oi, e, mem_word(e)); end
        end
    endtask

    task automatic test_redirect_handshake();
        settle();
        set_pc(32'h8);
        exp_addr_q = '{32'h8, 32'h200};
        exp_pc_q   = '{32'h200};
        halt = 1'b0;
        step();                            // REQ 0x8, handshake + redirect
        redirect_valid  = 1'b1;
        redirect_target = 32'h200;
        step();
        redirect_valid  = 1'b0;
        checks++; if (if_valid !== 1'b0) begin errors++; $display("FAIL rh_if_c2 got %0b exp 0", if_valid); end
        step();
        checks++; if (imem_req_valid !== 1'b1 || imem_addr !== 32'h200 || if_valid !== 1'b0) begin errors++; $display("FAIL rh_next_req got v=%0b a=%h if=%0b exp v=1 a=00000200 if=0", imem_req_valid, imem_addr, if_valid); end
        step();
        step();
        checks++; if (if_valid !== 1'b1 || if_pc !== 32'h200) begin errors++; $display("FAIL rh_hold got v=%0b pc=%h exp v=1 pc=00000200", if_valid, if_pc); end
        halt = 1'b1;
        repeat (6) step();
        checks++; if (iss_q.size() != exp_addr_q.size()) begin errors++; $display("FAIL rh_issue_count got %0d exp %0d", iss_q.size(), exp_addr_q.size()); end
        checks++; if (dpc_q.size() != exp_pc_q.size()) begin errors++; $display("FAIL rh_deliver_count got %0d exp %0d", dpc_q.size(), exp_pc_q.size()); end
        while (exp_addr_q.size() > 0) begin
            e = exp_addr_q.pop_front();
            o = (iss_q.size() > 0) ? iss_q.pop_front() : 32'hDEAD_BEEF;
            checks++; if (o !== e) begin errors++; $display("FAIL rh_addr got %h exp %h", o, e); end
        end
        while (exp_pc_q.size() > 0) begin
            e  = exp_pc_q.pop_front();
            o  = (dpc_q.size() > 0) ? dpc_q.pop_front() : 32'hDEAD_BEEF;
            oi = (dins_q.size() > 0) ? dins_q.pop_front() : 32'hDEAD_BEEF;
            checks++; if (o !== e || oi !== mem_word(e)) begin errors++; $display("FAIL rh_deliver got pc=%h i=%h exp pc=%h i=%h", o, oi, e, mem_word(e)); end
        end
    endtask

    task automatic test_hold_stall();
        settle();
        set_pc(32'h20);
        exp_addr_q = '{32'h20, 32'h24};
        exp_pc_q   = '{32'h20, 32'h24};
        if_ready = 1'b0;
        halt     = 1'b0;
        repeat (3) step();                 // HOLD
        for (int i = 0; i < 5; i++) begin
            checks++; if (if_valid !== 1'b1 || if_instr !== mem_word(32'h20) || imem_req_valid !== 1'b0) begin errors++; $display("FAIL hs_stall%0d got v=%0b i=%h req=%0b exp v=1 i=%h req=0", i, if_valid, if_instr, imem_req_valid, mem_word(32'h20)); end
            step();
        end
        checks++; if (if_instr !== mem_word(32'h20)) begin errors++; $display("FAIL hs_stable got %h exp %h", if_instr, mem_word(32'h20)); end
        if_ready = 1'b1;
        step();
        checks++; if (imem_req_valid !== 1'b1 || imem_addr !== 32'h24) begin errors++; $display("FAIL hs_release got v=%0b a=%h exp v=1 a=00000024", imem_req_valid, imem_addr); end
        halt = 1'b1;
        repeat (6) step();
        checks++; if (iss_q.size() != exp_addr_q.size()) begin errors++; $display("FAIL hs_issue_count got %0d exp %0d", iss_q.size(), exp_addr_q.size()); end
        checks++; if (dpc_q.size() != exp_pc_q.size()) begin errors++; $display("FAIL hs_deliver_count got %0d exp %0d", dpc_q.size(), exp_pc_q.size()); end
        while (exp_addr_q.size() > 0) begin
            e = exp_addr_q.pop_front();
            o = (iss_q.size() > 0) ? iss_q.pop_front() : 32'hDEAD_BEEF;
            checks++; if (o !== e) begin errors++; $display("FAIL hs_addr got %h exp %h", o, e); end
        end
        while (exp_pc_q.size() > 0) begin
            e  = exp_pc_q.pop_front();
            o  = (dpc_q.size() > 0) ? dpc_q.pop_front() : 32'hDEAD_BEEF;
            oi = (dins_q.size() > 0) ? dins_q.pop_front() : 32'hDEAD_BEEF;
            checks++; if (o !== e || oi !== mem_word(e)) begin errors++; $display("FAIL hs_deliver got pc=%h i=%h exp pc=%h i=%h", o, oi, e, mem_word(e)); end
        end
    endtask

    task automatic test_wrap();
        settle();
        set_pc(32'hFFFF_FFFC);
        exp_addr_q = '{32'hFFFF_FFFC, 32'h0};
        exp_pc_q   = '{32'hFFFF_FFFC, 32'h0};
        halt = 1'b0;
        repeat (4) step();
        checks++; if (imem_req_valid !== 1'b1 || imem_addr !== 32'h0) begin errors++; $display("FAIL wrap_req got v=%0b a=%h exp v=1 a=00000000", imem_req_valid, imem_addr); end
        repeat (2) step();
        halt = 1'b1;
        repeat (6) step();
        checks++; if (iss_q.size() != exp_addr_q.size()) begin errors++; $display("FAIL wrap_issue_count got %0d exp %0d", iss_q.size(), exp_addr_q.size()); end
        checks++; if (dpc_q.size() != exp_pc_q.size()) begin errors++; $display("FAIL wrap_deliver_count got %0d exp %0d", dpc_q.size(), exp_pc_q.size()); end
        while (exp_addr_q.size() > 0) begin
            e = exp_addr_q.pop_front();
            o = (iss_q.size() > 0) ? iss_q.pop_front() : 32'hDEAD_BEEF;
            checks++; if (o !== e) begin errors++; $display("FAIL wrap_addr got %h exp %h", o, e); end
        end
        while (exp_pc_q.size() > 0) begin
            e  = exp_pc_q.pop_front();
            o  = (dpc_q.size() > 0) ? dpc_q.pop_front() : 32'hDEAD_BEEF;
            oi = (dins_q.size() > 0) ? dins_q.pop_front() : 32'hDEAD_BEEF;
            checks++; if (o !== e || oi !== mem_word(e)) begin errors++; $display("FAIL wrap_deliver got pc=%h i=%h exp pc=%h i=%h", o, oi, e, mem_word(e)); end
        end
    endtask

    task automatic test_reset_mid_wait();
        settle();
        set_pc(32'h60);
        rsp_lat = 3;
        halt    = 1'b0;
        step();                            // REQ 0x60 accepted
        step();                            // WAIT
        rst  = 1'b1;
        halt = 1'b1;
        step();
        rst  = 1'b0;
        for (int i = 0; i < 5; i++) begin
            checks++; if (if_valid !== 1'b0 || imem_req_valid !== 1'b0) begin errors++; $display("FAIL rmw_idle%0d got if=%0b req=%0b exp if=0 req=0", i, if_valid, imem_req_valid); end
            step();
        end
        checks++; if (dpc_q.size() != 0) begin errors++; $display("FAIL rmw_deliver_count got %0d exp 0", dpc_q.size()); end
        checks++; if (imem_addr !== 32'h0) begin errors++; $display("FAIL rmw_pc got %h exp 00000000", imem_addr); end
    endtask

    task automatic test_misalign();
        settle();
        set_pc(32'h80);
        exp_addr_q.push_back(32'h80);
        halt = 1'b0;
        step();                            // REQ 0x80 accepted
        step();                            // WAIT, response this cycle
        redirect_valid  = 1'b1;
        redirect_target = 32'h102;
        step();
        redirect_valid  = 1'b0;
`ifdef PC_CTRL_MISALIGN_TRAP_EN
        for (int i = 0; i < 5; i++) begin
            checks++; if (misalign_fault !== 1'b1 || imem_req_valid !== 1'b0 || if_valid !== 1'b0) begin errors++; $display("FAIL mis_fault%0d got f=%0b req=%0b if=%0b exp f=1 req=0 if=0", i, misalign_fault, imem_req_valid, if_valid); end
            step();
        end
        halt = 1'b1;
`else
        exp_addr_q.push_back(32'h100);
        exp_pc_q.push_back(32'h100);
        checks++; if (misalign_fault !== 1'b0 || imem_req_valid !== 1'b1 || imem_addr !== 32'h100) begin errors++; $display("FAIL mis_aligned got f=%0b v=%0b a=%h exp f=0 v=1 a=00000100", misalign_fault, imem_req_valid, imem_addr); end
        step();
        step();
        halt = 1'b1;
        repeat (6) step();
`endif
        checks++; if (iss_q.size() != exp_addr_q.size()) begin errors++; $display("FAIL mis_issue_count got %0d exp %0d", iss_q.size(), exp_addr_q.size()); end
        checks++; if (dpc_q.size() != exp_pc_q.size()) begin errors++; $display("FAIL mis_deliver_count got %0d exp %0d", dpc_q.size(), exp_pc_q.size()); end
        while (exp_addr_q.size() > 0) begin
            e = exp_addr_q.pop_front();
            o = (iss_q.size() > 0) ? iss_q.pop_front() : 32'hDEAD_BEEF;
            checks++; if (o !== e) begin errors++; $display("FAIL mis_addr got %h exp %h", o, e); end
        end
        while (exp_pc_q.size() > 0) begin
            e  = exp_pc_q.pop_front();
            o  = (dpc_q.size() > 0) ? dpc_q.pop_front() : 32'hDEAD_BEEF;
            oi = (dins_q.size() > 0) ? dins_q.pop_front() : 32'hDEAD_BEEF;
            checks++; if (o !== e || oi !== mem_word(e)) begin errors++; $display("FAIL mis_deliver got pc=%h i=%h exp pc=%h i=%h", o, oi, e, mem_word(e)); end
        end
        rst = 1'b1;
        step();
        rst = 1'b0;
        step();
        checks++; if (misalign_fault !== 1'b0) begin errors++; $display("FAIL mis_cleared got %0b exp 0", misalign_fault); end
    endtask

    initial begin
        rst             = 1'b1;
        halt            = 1'b1;
        imem_req_ready  = 1'b1;
        if_ready        = 1'b1;
        redirect_valid  = 1'b0;
        redirect_target = '0;
        test_reset();
        test_sequential();
        test_redirect_wait();
        test_redirect_handshake();
        test_hold_stall();
        test_wrap();
        test_reset_mid_wait();
        test_misalign();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
